mem_stage: RTL and testbench

//   Pipeline stage downstream of the execute stage. Registers the 155-bit EXE->MEM bus and performs word

---
 rtl/riscv_pipe_pkg.sv | 70 +++++++
 rtl/mem_dmem_fsm.sv | 97 +++++++++
 rtl/mem_stage.sv | 82 ++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: EXE->MEM and MEM->WB bus layouts, field offsets,
// MEM-stage FSM state encoding and write-back select codes.
package riscv_pipe_pkg;

    localparam int unsigned EXE_MEM_W = 155;
    localparam int unsigned MEM_WB_W  = 153;

    // EXE->MEM field LSB positions (MSB-first packing)
    localparam int unsigned EM_OP1_LSB      = 0;
    localparam int unsigned EM_CSR_ADDR_LSB = 32;
    localparam int unsigned EM_CSR_CMD_LSB  = 44;
    localparam int unsigned EM_WB_DATA_LSB  = 48;
    localparam int unsigned EM_PC_LSB       = 80;
    localparam int unsigned EM_WB_SEL_LSB   = 112;
    localparam int unsigned EM_MEM_RE_BIT   = 115;
    localparam int unsigned EM_MEM_WE_BIT   = 116;
    localparam int unsigned EM_RD_WEN_BIT   = 117;
    localparam int unsigned EM_RD_LSB       = 118;
    localparam int unsigned EM_ALU_LSB      = 123;

    // MEM->WB field LSB positions
    localparam int unsigned MW_OP1_LSB      = 0;
    localparam int unsigned MW_CSR_ADDR_LSB = 32;
    localparam int unsigned MW_CSR_CMD_LSB  = 44;
    localparam int unsigned MW_PC_LSB       = 48;
    localparam int unsigned MW_WB_SEL_LSB   = 80;
    localparam int unsigned MW_RD_WEN_BIT   = 83;
    localparam int unsigned MW_RD_LSB       = 84;
    localparam int unsigned MW_LOAD_LSB     = 89;
    localparam int unsigned MW_ALU_LSB      = 121;

    localparam logic [2:0] WB_SEL_ALU = 3'd0;
    localparam logic [2:0] WB_SEL_MEM = 3'd1;
    localparam logic [2:0] WB_SEL_PC4 = 3'd2;
    localparam logic [2:0] WB_SEL_CSR = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] wb_data;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1_data;
    } exe_mem_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1_data;
    } mem_wb_t;

endpackage

// File: rtl/mem_dmem_fsm.sv
// Data-memory access sequencer: req/gnt/rvalid handshake, timeout counter,
// captured load word and fault flag for the instruction held in MEM.
module mem_dmem_fsm
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_mem_op_i,
    input  logic        new_misaligned_i,
    input  logic        cur_we_i,
    input  logic        cur_re_i,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             fault_q, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // IDLE/DONE accept the incoming instruction; REQ/RESP hold it until handshake or timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_gnt_i && cur_we_i) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else if (dmem_gnt_i && cur_re_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid_i) begin
                    state_d = ST_DONE;
                    rdata_d = dmem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                rdata_d = '0;
                fault_d = new_misaligned_i;
                if (new_misaligned_i) begin
                    state_d = ST_DONE;
                end else if (new_mem_op_i) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign dmem_req_o = (state_q == ST_REQ);
    assign dmem_we_o  = dmem_req_o & cur_we_i;
    assign stall_o    = (state_q == ST_REQ) | (state_q == ST_RESP);
    assign fault_o    = (state_q == ST_DONE) & fault_q;
    assign rdata_o    = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXE->MEM bus, runs word loads/stores on
// the data-memory port and produces the MEM->WB and MEM hazard buses.
module mem_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EXE_MEM_W-1:0] exe_mem_bus_in,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    output logic [MEM_WB_W-1:0]  mem_wb_bus_out,
    output logic [5:0]           mem_id_data_bus,
    output logic                 mem_fault
);

    exe_mem_t    in_new, in_q;
    mem_wb_t     wb;
    logic        new_mem_op, new_misaligned, wb_mask;
    logic [31:0] load_data;

    assign in_new         = exe_mem_bus_in;
    assign new_mem_op     = in_new.mem_re | in_new.mem_we;
    assign new_misaligned = new_mem_op & (in_new.alu_result[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else if (!mem_stall) begin
            in_q <= in_new;
        end
    end

    mem_dmem_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk              (clk),
        .rst_n            (rst_n),
        .new_mem_op_i     (new_mem_op),
        .new_misaligned_i (new_misaligned),
        .cur_we_i         (in_q.mem_we),
        .cur_re_i         (in_q.mem_re),
        .dmem_gnt_i       (dmem_gnt),
        .dmem_rvalid_i    (dmem_rvalid),
        .dmem_rdata_i     (dmem_rdata),
        .dmem_req_o       (dmem_req),
        .dmem_we_o        (dmem_we),
        .stall_o          (mem_stall),
        .fault_o          (mem_fault),
        .rdata_o          (load_data)
    );

    assign dmem_addr  = {in_q.alu_result[31:2], 2'b00};
    assign dmem_wdata = in_q.wb_data;

    // Stalled or faulted instructions must not commit a register or CSR write
    assign wb_mask = mem_stall | mem_fault;

    always_comb begin
        wb            = '0;
        wb.alu_result = in_q.alu_result;
        wb.load_data  = load_data;
        wb.rd         = in_q.rd;
        wb.rd_wen     = in_q.rd_wen & ~wb_mask;
        wb.wb_sel     = in_q.wb_sel;
        wb.pc         = in_q.pc;
        wb.csr_cmd    = wb_mask ? 4'h0 : in_q.csr_cmd;
        wb.csr_addr   = in_q.csr_addr;
        wb.op1_data   = in_q.op1_data;
    end

    assign mem_wb_bus_out  = wb;
    assign mem_id_data_bus = {in_q.rd, in_q.rd_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM->WB words are queued as each
// instruction is driven and compared when the stage releases it.
module tb_mem_stage;
    import riscv_pipe_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [EXE_MEM_W-1:0] exe_mem_bus_in;
    logic                 mem_stall, dmem_req, dmem_we, mem_fault;
    logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
    logic                 dmem_gnt, dmem_rvalid;
    logic [MEM_WB_W-1:0]  mem_wb_bus_out;
    logic [5:0]           mem_id_data_bus;

    int vectors     = 0;
    int miscompares = 0;
    logic [MEM_WB_W-1:0] exp_q[$];
    logic [MEM_WB_W-1:0] exp_v;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exe_mem_bus_in  (exe_mem_bus_in),
        .mem_stall       (mem_stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .mem_wb_bus_out  (mem_wb_bus_out),
        .mem_id_data_bus (mem_id_data_bus),
        .mem_fault       (mem_fault)
    );

    function automatic logic [EXE_MEM_W-1:0] pack_exe(
        input logic [31:0] alu, input logic [4:0] rd, input logic rd_wen,
        input logic we, input logic re, input logic [2:0] wb_sel,
        input logic [31:0] pc, input logic [31:0] wb_data, input logic [3:0] csr_cmd,
        input logic [11:0] csr_addr, input logic [31:0] op1);
        logic [EXE_MEM_W-1:0] v;
        v = '0;
        v[EM_ALU_LSB +: 32]      = alu;
        v[EM_RD_LSB +: 5]        = rd;
        v[EM_RD_WEN_BIT]         = rd_wen;
        v[EM_MEM_WE_BIT]         = we;
        v[EM_MEM_RE_BIT]         = re;
        v[EM_WB_SEL_LSB +: 3]    = wb_sel;
        v[EM_PC_LSB +: 32]       = pc;
        v[EM_WB_DATA_LSB +: 32]  = wb_data;
        v[EM_CSR_CMD_LSB +: 4]   = csr_cmd;
        v[EM_CSR_ADDR_LSB +: 12] = csr_addr;
        v[EM_OP1_LSB +: 32]      = op1;
        return v;
    endfunction

    function automatic logic [MEM_WB_W-1:0] pack_wb(
        input logic [31:0] alu, input logic [31:0] load, input logic [4:0] rd,
        input logic rd_wen, input logic [2:0] wb_sel, input logic [31:0] pc,
        input logic [3:0] csr_cmd, input logic [11:0] csr_addr, input logic [31:0] op1);
        logic [MEM_WB_W-1:0] v;
        v = '0;
        v[MW_ALU_LSB +: 32]      = alu;
        v[MW_LOAD_LSB +: 32]     = load;
        v[MW_RD_LSB +: 5]        = rd;
        v[MW_RD_WEN_BIT]         = rd_wen;
        v[MW_WB_SEL_LSB +: 3]    = wb_sel;
        v[MW_PC_LSB +: 32]       = pc;
        v[MW_CSR_CMD_LSB +: 4]   = csr_cmd;
        v[MW_CSR_ADDR_LSB +: 12] = csr_addr;
        v[MW_OP1_LSB +: 32]      = op1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exe_mem_bus_in = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) tick();
        vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
        vectors++; if ({dmem_req, dmem_we} !== 2'b00) begin miscompares++; $display("FAIL reset_req_we: got %b want 00", {dmem_req, dmem_we}); end
        vectors++; if (mem_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", mem_fault); end
        vectors++; if ({dmem_addr, dmem_wdata} !== 64'h0) begin miscompares++; $display("FAIL reset_addr_wdata: got %h want 0", {dmem_addr, dmem_wdata}); end
        vectors++; if (mem_wb_bus_out !== '0) begin miscompares++; $display("FAIL reset_wb_bus: got %h want 0", mem_wb_bus_out); end
        vectors++; if (mem_id_data_bus !== 6'h0) begin miscompares++; $display("FAIL reset_id_bus: got %h want 0", mem_id_data_bus); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        exp_q.push_back(pack_wb(32'h10, 32'h0, 5'd5, 1'b1, WB_SEL_ALU, 32'h1000, 4'h0, 12'h0, 32'h55));
        exe_mem_bus_in = pack_exe(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, WB_SEL_ALU, 32'h1000, 32'h0, 4'h0, 12'h0, 32'h55);
        tick();
        exe_mem_bus_in = '0;
        vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL add_stall: got %b want 0", mem_stall); end
        vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL add_req: got %b want 0", dmem_req); end
        vectors++; if (mem_id_data_bus !== {5'd5, 1'b1}) begin miscompares++; $display("FAIL add_id_bus: got %h want %h", mem_id_data_bus, {5'd5, 1'b1}); end
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL add_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL add_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
    endtask

    task automatic test_store();
        exp_q.push_back(pack_wb(32'h100, 32'h0, 5'd6, 1'b1, WB_SEL_ALU, 32'h2000, 4'h5, 12'h341, 32'h0));
        exe_mem_bus_in = pack_exe(32'h100, 5'd6, 1'b1, 1'b1, 1'b0, WB_SEL_ALU, 32'h2000, 32'hDEADBEEF, 4'h5, 12'h341, 32'h0);
        tick();
        exe_mem_bus_in = '0;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (mem_stall !== 1'b1) begin miscompares++; $display("FAIL st_stall c%0d: got %b want 1", c, mem_stall); end
            vectors++; if ({dmem_req, dmem_we} !== 2'b11) begin miscompares++; $display("FAIL st_req_we c%0d: got %b want 11", c, {dmem_req, dmem_we}); end
            vectors++; if ({dmem_addr, dmem_wdata} !== {32'h100, 32'hDEADBEEF}) begin miscompares++; $display("FAIL st_addr_data c%0d: got %h want 00000100deadbeef", c, {dmem_addr, dmem_wdata}); end
            vectors++; if ({mem_wb_bus_out[MW_RD_WEN_BIT], mem_wb_bus_out[MW_CSR_CMD_LSB +: 4]} !== 5'h0) begin miscompares++; $display("FAIL st_bubble c%0d: got %h want 0", c, {mem_wb_bus_out[MW_RD_WEN_BIT], mem_wb_bus_out[MW_CSR_CMD_LSB +: 4]}); end
            dmem_gnt = (c == 2);
            tick();
        end
        dmem_gnt = 1'b0;
        vectors++; if ({mem_stall, dmem_req, mem_fault} !== 3'b000) begin miscompares++; $display("FAIL st_done: got %b want 000", {mem_stall, dmem_req, mem_fault}); end
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL st_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL st_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
    endtask

    task automatic test_load();
        exp_q.push_back(pack_wb(32'h200, 32'h12345678, 5'd7, 1'b1, WB_SEL_MEM, 32'h3000, 4'h0, 12'h0, 32'h0));
        exe_mem_bus_in = pack_exe(32'h200, 5'd7, 1'b1, 1'b0, 1'b1, WB_SEL_MEM, 32'h3000, 32'h0, 4'h0, 12'h0, 32'h0);
        tick();
        exe_mem_bus_in = '0;
        for (int c = 0; c < 4; c++) begin
            vectors++; if (mem_stall !== 1'b1) begin miscompares++; $display("FAIL ld_stall c%0d: got %b want 1", c, mem_stall); end
            vectors++; if ({dmem_req, dmem_we} !== {(c == 0), 1'b0}) begin miscompares++; $display("FAIL ld_req c%0d: got %b want %b", c, {dmem_req, dmem_we}, {(c == 0), 1'b0}); end
            vectors++; if (mem_wb_bus_out[MW_RD_WEN_BIT] !== 1'b0) begin miscompares++; $display("FAIL ld_bubble c%0d: got %b want 0", c, mem_wb_bus_out[MW_RD_WEN_BIT]); end
            vectors++; if (mem_id_data_bus !== {5'd7, 1'b1}) begin miscompares++; $display("FAIL ld_id_bus c%0d: got %h want %h", c, mem_id_data_bus, {5'd7, 1'b1}); end
            dmem_gnt    = (c <= 1);
            dmem_rvalid = (c == 0) || (c == 3);
            dmem_rdata  = (c == 3) ? 32'h12345678 : 32'hBADBAD00;
            tick();
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        vectors++; if ({mem_stall, dmem_req, mem_fault} !== 3'b000) begin miscompares++; $display("FAIL ld_done: got %b want 000", {mem_stall, dmem_req, mem_fault}); end
        vectors++; if (mem_wb_bus_out[MW_LOAD_LSB +: 32] !== 32'h12345678) begin miscompares++; $display("FAIL ld_data: got %h want 12345678", mem_wb_bus_out[MW_LOAD_LSB +: 32]); end
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL ld_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL ld_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
        vectors++; if (mem_wb_bus_out[MW_LOAD_LSB +: 32] !== 32'h0) begin miscompares++; $display("FAIL ld_data_clear: got %h want 0", mem_wb_bus_out[MW_LOAD_LSB +: 32]); end
    endtask

    task automatic test_misaligned();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] alu, pc;
            logic        we;
            alu = (k == 0) ? 32'h203 : 32'h102;
            we  = (k == 1);
            pc  = 32'(32'h4000 + k * 4);
            exp_q.push_back(pack_wb(alu, 32'h0, 5'd9, 1'b0, WB_SEL_MEM, pc, 4'h0, 12'h300, 32'h77));
            exe_mem_bus_in = pack_exe(alu, 5'd9, 1'b1, we, ~we, WB_SEL_MEM, pc, 32'hCAFE0000, 4'h1, 12'h300, 32'h77);
            tick();
            exe_mem_bus_in = '0;
            vectors++; if ({dmem_req, mem_stall, mem_fault} !== 3'b001) begin miscompares++; $display("FAIL mis_flags k%0d: got %b want 001", k, {dmem_req, mem_stall, mem_fault}); end
            vectors++; if (mem_id_data_bus !== {5'd9, 1'b1}) begin miscompares++; $display("FAIL mis_id_bus k%0d: got %h want %h", k, mem_id_data_bus, {5'd9, 1'b1}); end
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL mis_sb k%0d: scoreboard empty", k); end
            else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL mis_wb k%0d: got %h want %h", k, mem_wb_bus_out, exp_v); end end
            tick();
            vectors++; if (mem_fault !== 1'b0) begin miscompares++; $display("FAIL mis_pulse k%0d: got %b want 0", k, mem_fault); end
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back(pack_wb(32'h300, 32'h0, 5'd3, 1'b0, WB_SEL_MEM, 32'h5000, 4'h0, 12'h0, 32'h0));
        exe_mem_bus_in = pack_exe(32'h300, 5'd3, 1'b1, 1'b0, 1'b1, WB_SEL_MEM, 32'h5000, 32'h0, 4'h0, 12'h0, 32'h0);
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        exe_mem_bus_in = '0;
        for (int c = 0; c < 16; c++) begin
            vectors++; if ({mem_stall, dmem_req, mem_fault} !== 3'b110) begin miscompares++; $display("FAIL to_wait c%0d: got %b want 110", c, {mem_stall, dmem_req, mem_fault}); end
            tick();
        end
        vectors++; if ({mem_stall, dmem_req, mem_fault} !== 3'b001) begin miscompares++; $display("FAIL to_done: got %b want 001", {mem_stall, dmem_req, mem_fault}); end
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL to_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL to_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
        vectors++; if (mem_fault !== 1'b0) begin miscompares++; $display("FAIL to_pulse: got %b want 0", mem_fault); end
    endtask

    task automatic test_reset_mid_access();
        exe_mem_bus_in = pack_exe(32'h400, 5'd4, 1'b1, 1'b0, 1'b1, WB_SEL_MEM, 32'h6000, 32'h0, 4'h0, 12'h0, 32'h0);
        tick();
        exe_mem_bus_in = '0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        vectors++; if ({mem_stall, dmem_req} !== 2'b10) begin miscompares++; $display("FAIL rst_resp: got %b want 10", {mem_stall, dmem_req}); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({mem_stall, dmem_req} !== 2'b00) begin miscompares++; $display("FAIL rst_async: got %b want 00", {mem_stall, dmem_req}); end
        vectors++; if (mem_wb_bus_out !== '0) begin miscompares++; $display("FAIL rst_async_wb: got %h want 0", mem_wb_bus_out); end
        repeat (2) tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000BEEF;
        tick();
        dmem_rvalid = 1'b0;
        vectors++; if ({mem_stall, dmem_req, mem_fault} !== 3'b000) begin miscompares++; $display("FAIL rst_late_rvalid: got %b want 000", {mem_stall, dmem_req, mem_fault}); end
        vectors++; if (mem_wb_bus_out !== '0) begin miscompares++; $display("FAIL rst_late_wb: got %h want 0", mem_wb_bus_out); end
        exp_q.push_back(pack_wb(32'h10, 32'h0, 5'd5, 1'b1, WB_SEL_ALU, 32'h1004, 4'h0, 12'h0, 32'h1));
        exe_mem_bus_in = pack_exe(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, WB_SEL_ALU, 32'h1004, 32'h0, 4'h0, 12'h0, 32'h1);
        tick();
        exe_mem_bus_in = '0;
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL rst_add_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL rst_add_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] alu;
            logic [4:0]  rd;
            logic [2:0]  sel;
            logic [3:0]  cmd;
            alu = 32'(32'h40 + i * 4);
            rd  = 5'(i + 1);
            sel = (i == 1) ? WB_SEL_CSR : WB_SEL_PC4;
            cmd = (i == 1) ? 4'h2 : 4'h0;
            exp_q.push_back(pack_wb(alu, 32'h0, rd, 1'b1, sel, 32'h7000 + alu, cmd, 12'h305, 32'hA5A5A5A5));
            exe_mem_bus_in = pack_exe(alu, rd, 1'b1, 1'b0, 1'b0, sel, 32'h7000 + alu, 32'h0, cmd, 12'h305, 32'hA5A5A5A5);
            tick();
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_sb i%0d: scoreboard empty", i); end
            else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL b2b_wb i%0d: got %h want %h", i, mem_wb_bus_out, exp_v); end end
        end
        exp_q.push_back(pack_wb(32'h180, 32'h0, 5'd0, 1'b0, WB_SEL_ALU, 32'h8000, 4'h0, 12'h0, 32'h0));
        exe_mem_bus_in = pack_exe(32'h180, 5'd0, 1'b0, 1'b1, 1'b0, WB_SEL_ALU, 32'h8000, 32'h11223344, 4'h0, 12'h0, 32'h0);
        dmem_gnt = 1'b1;
        tick();
        exp_q.push_back(pack_wb(32'h99, 32'h0, 5'd12, 1'b1, WB_SEL_ALU, 32'h8004, 4'h0, 12'h0, 32'h3));
        exe_mem_bus_in = pack_exe(32'h99, 5'd12, 1'b1, 1'b0, 1'b0, WB_SEL_ALU, 32'h8004, 32'h0, 4'h0, 12'h0, 32'h3);
        vectors++; if ({mem_stall, dmem_req, dmem_we} !== 3'b111) begin miscompares++; $display("FAIL b2b_st_req: got %b want 111", {mem_stall, dmem_req, dmem_we}); end
        tick();
        dmem_gnt = 1'b0;
        vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_st_done: got %b want 0", mem_stall); end
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_st_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL b2b_st_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
        exe_mem_bus_in = '0;
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_next_sb: scoreboard empty"); end
        else begin exp_v = exp_q.pop_front(); if (mem_wb_bus_out !== exp_v) begin miscompares++; $display("FAIL b2b_next_wb: got %h want %h", mem_wb_bus_out, exp_v); end end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_store();
        test_load();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
